// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin bus arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int N_REQ            = 8;
  localparam int ID_W             = 3;
  localparam int MAX_HOLD_DEFAULT = 16;

endpackage

// File: rtl/or8way.sv
// 8-input OR reduction.
// Latency: combinational. Backpressure: none.
module Or8Way (
  input  logic [7:0] in,
  output logic       out
);

  assign out = |in;

endmodule

// File: rtl/rr_pick8.sv
// Rotating-priority picker: first set request at or after ptr, modulo 8.
// Latency: combinational. Backpressure: none.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             any,
  output logic [ID_W-1:0]  sel_id,
  output logic [N_REQ-1:0] sel_onehot
);

  logic [N_REQ-1:0] rot;
  logic [ID_W-1:0]  off;

  Or8Way u_any (
    .in  (req),
    .out (any)
  );

  always_comb begin
    rot = '0;
    off = '0;
    // rot[i] is the request i positions after ptr, so rot[0] has top priority
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[ID_W'(i) + ptr];
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = ID_W'(i);
    end
  end

  assign sel_id     = any ? (off + ptr) : '0;
  assign sel_onehot = any ? (N_REQ'(1) << sel_id) : '0;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter, 8 requesters, one dead cycle between owners; RR_HOLD_TIMEOUT_EN caps a hold at MAX_HOLD cycles.
// Latency: req to gnt 1 cycle. Backpressure: grant held while owner keeps req high; others wait.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_id,
  output logic             busy
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter8: MAX_HOLD out of range 2..255");
  end

  state_t           state, state_n;
  logic [ID_W-1:0]  ptr, ptr_n;
  logic [N_REQ-1:0] gnt_n;
  logic [ID_W-1:0]  id_n;
  logic             any;
  logic [ID_W-1:0]  sel_id;
  logic [N_REQ-1:0] sel_onehot;
  logic             timeout;

  rr_pick8 u_pick (
    .req        (req),
    .ptr        (ptr),
    .any        (any),
    .sel_id     (sel_id),
    .sel_onehot (sel_onehot)
  );

`ifdef RR_HOLD_TIMEOUT_EN
  logic [7:0] hold_cnt, hold_cnt_n;

  // Counter reads 0 in the first grant cycle, so MAX_HOLD-1 marks the last one
  assign timeout = (hold_cnt == 8'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt <= '0;
    else        hold_cnt <= hold_cnt_n;
  end

  always_comb begin
    hold_cnt_n = hold_cnt;
    if (state != GRANT)  hold_cnt_n = '0;
    else if (state_n == GRANT) hold_cnt_n = hold_cnt + 8'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = gnt;
    id_n    = gnt_id;
    case (state)
      IDLE, GAP: begin
        if (any) begin
          state_n = GRANT;
          gnt_n   = sel_onehot;
          id_n    = sel_id;
        end else begin
          state_n = IDLE;
          gnt_n   = '0;
          id_n    = '0;
        end
      end
      GRANT: begin
        // Release wins over any new request; newcomers are picked in GAP
        if (!req[gnt_id] || timeout) begin
          state_n = GAP;
          gnt_n   = '0;
          id_n    = '0;
          ptr_n   = gnt_id + ID_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        id_n    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      gnt    <= '0;
      gnt_id <= '0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      gnt    <= gnt_n;
      gnt_id <= id_n;
    end
  end

  assign gnt_valid = |gnt;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: expected grants queued at drive time, popped after each edge.
module tb_rr_arbiter8;

  typedef struct packed {
    logic [7:0] gnt;
    logic       busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_id;
  logic       busy;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] enc(input logic [7:0] g);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (g[i]) r = 3'(i);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic compare_outputs(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".gnt"},       gnt,              e.gnt);
    chk({tag, ".busy"},      {7'd0, busy},     {7'd0, e.busy});
    chk({tag, ".gnt_valid"}, {7'd0, gnt_valid}, {7'd0, |e.gnt});
    chk({tag, ".gnt_id"},    {5'd0, gnt_id},   {5'd0, enc(e.gnt)});
  endtask

  // Drive req for one cycle and check outputs just after the sampling edge
  task automatic step(input string tag, input logic [7:0] r, input logic [7:0] eg, input logic eb);
    req = r;
    sb.push_back('{gnt: eg, busy: eb});
    @(posedge clk);
    #1;
    compare_outputs(tag);
  endtask

  initial begin
    // Reset held with every requester active
    req = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.known_req", {7'd0, $isunknown(req)}, 8'd0);
    sb.push_back('{gnt: 8'h00, busy: 1'b0});
    compare_outputs("reset");
    rst_n = 1'b1;
    step("first_grant", 8'hFF, 8'h01, 1'b1);

    // Fairness: each owner holds 3 cycles, drops for one, then everyone re-requests
    for (int k = 0; k < 8; k++) begin
      step("hold", 8'hFF, 8'h01 << k, 1'b1);
      step("hold", 8'hFF, 8'h01 << k, 1'b1);
      step("gap", 8'hFF & ~(8'h01 << k), 8'h00, 1'b1);
      step("next", 8'hFF, 8'h01 << ((k + 1) % 8), 1'b1);
    end

    // Pointer wrap: owner 6 releases, ptr=7, requests 0 and 6 -> 0 wins
    step("wrap.rel0", 8'h40, 8'h00, 1'b1);
    step("wrap.g6", 8'h40, 8'h40, 1'b1);
    step("wrap.rel6", 8'h00, 8'h00, 1'b1);
    step("wrap.g0", 8'h41, 8'h01, 1'b1);
    step("idle.gap", 8'h00, 8'h00, 1'b1);
    step("idle", 8'h00, 8'h00, 1'b0);

    // Owner 2 drops while 5 rises: gap first, then 5
    step("sim.g2", 8'h04, 8'h04, 1'b1);
    step("sim.hold2", 8'h04, 8'h04, 1'b1);
    step("sim.gap", 8'h20, 8'h00, 1'b1);
    step("sim.g5", 8'h20, 8'h20, 1'b1);
    step("sim.rel", 8'h00, 8'h00, 1'b1);
    step("sim.idle", 8'h00, 8'h00, 1'b0);

    // One-cycle pulse from idle
    step("pulse.g7", 8'h80, 8'h80, 1'b1);
    step("pulse.rel", 8'h00, 8'h00, 1'b1);
    step("pulse.idle", 8'h00, 8'h00, 1'b0);

    // Async reset in the middle of a grant
    step("arst.g3", 8'h08, 8'h08, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back('{gnt: 8'h00, busy: 1'b0});
    compare_outputs("arst.async_clear");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("arst.ptr0", 8'h0C, 8'h04, 1'b1);
    step("arst.rel", 8'h00, 8'h00, 1'b1);
    step("arst.idle", 8'h00, 8'h00, 1'b0);

`ifdef RR_HOLD_TIMEOUT_EN
    for (int c = 0; c < 4; c++) step("to.g0", 8'h03, 8'h01, 1'b1);
    step("to.gap0", 8'h03, 8'h00, 1'b1);
    for (int c = 0; c < 4; c++) step("to.g1", 8'h03, 8'h02, 1'b1);
    step("to.gap1", 8'h03, 8'h00, 1'b1);
    step("to.g0_again", 8'h03, 8'h01, 1'b1);
`else
    for (int c = 0; c < 10; c++) step("nto.hold0", 8'h03, 8'h01, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Structural invariants sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      assert ((gnt & (gnt - 8'd1)) == 8'd0 && gnt_valid === (|gnt)) else begin
        errors++;
        $error("FAIL invariant: gnt %h gnt_valid %b expected one-hot/zero with matching valid", gnt, gnt_valid);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters, such as the memory/IO bus of the HACK platform.
- An 8-bit request vector is reduced with an Or8Way instance to form "any request".
- A rotating-priority picker selects one requester.
- The grant is held until the owner drops its request.
- One dead cycle is inserted between owners so that bus drivers never overlap.

Parameters:
- N_REQ, 8: number of requesters. Fixed at 8; kept for documentation and assertions only.
- MAX_HOLD, 16: maximum consecutive grant cycles when RR_HOLD_TIMEOUT_EN is defined. Legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request vector; bit i high = requester i wants the resource; held high for as long as it is in use.
- gnt  output  8  one-hot grant, registered; all zero when no owner.
- gnt_valid  output  1  high when gnt is non-zero.
- gnt_id  output  3  index of the current owner; 0 when gnt_valid is low.
- busy  output  1  high in the GRANT or GAP state.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: gnt=0, gnt_valid=0, gnt_id=0, busy=0, state=IDLE, priority pointer ptr=0.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If any req is high at edge t, the picker selects the first set bit scanning ptr, ptr+1, ... modulo 8.
  - gnt is then set one-hot at edge t (visible in cycle t+1). State goes to GRANT.
  - Latency from req rise to gnt is 1 cycle.
- GRANT:
  - While req[gnt_id]=1, the grant is held; other requests are ignored.
  - When req[gnt_id]=0 is sampled, gnt is cleared on that edge, ptr becomes (gnt_id+1) mod 8 (wrap 7->0), and state goes to GAP.
- GAP:
  - Exactly one cycle with gnt=0 and busy=1.
  - The next edge re-evaluates as in IDLE: if any req is high, grant directly (GAP->GRANT); otherwise go to IDLE.
- Minimum spacing between two grants is therefore 1 zero cycle.
- The picker is combinational.
  - The request vector is rotated right by ptr and priority-encoded (lowest index wins), then the index is rotated back.
  - The rotation is modulo-8 arithmetic on 3 bits.
- Boundary conditions:
  - Single requester held continuously: it is re-granted after each release + GAP; no starvation logic is needed.
  - All 8 requesting: grants cycle strictly ptr order 0,1,...,7,0.
  - Owner drops req in the same cycle a new req rises: release takes priority; the new req is considered in GAP.
  - req pulses for 1 cycle in IDLE: granted for 1 cycle, then released on the next edge since req is low.
  - rst_n asserted mid-GRANT: gnt clears immediately (async); ptr resets to 0.
  - X/undefined req bits are not tolerated; the bench asserts known values after reset.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt_valid == |gnt.
  - gnt_id encodes gnt.

Optional Feature:
- Macro: RR_HOLD_TIMEOUT_EN.
- Defined:
  - A hold counter of 8 bits, cleared on every grant, increments each GRANT cycle.
  - When the counter reaches MAX_HOLD-1 with req still high, gnt is forcibly cleared on that edge.
  - The owner therefore holds for exactly MAX_HOLD cycles. ptr advances past it and state goes to GAP.
  - The preempted requester re-competes normally.
- Undefined: no counter; a grant is held indefinitely while req stays high.

Decomposition:
- Package arb_pkg holds:
  - state encoding: IDLE=2'd0, GRANT=2'd1, GAP=2'd2
  - N_REQ=8
  - ID_W=3
  - MAX_HOLD default
- Sub-module rr_pick8 (combinational):
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: any, sel_id[2:0], sel_onehot[7:0].
  - "any" comes from an Or8Way instance.
- The top level holds the FSM, ptr, the output registers and the optional counter.

Test Plan:
- Reset: rst_n=0 with req=8'hFF -> gnt=0, gnt_valid=0, busy=0. Release reset -> gnt=8'h01 one cycle later.
- Fairness: req=8'hFF held, each owner drops req for 1 cycle after 3 cycles of grant, then re-raises -> grant order 0,1,2,...,7,0, with exactly one gnt=0 cycle between owners.
- Pointer wrap: after owner 6 releases, req=8'b0100_0001 -> next gnt=8'h01 (index 0 via wrap from ptr=7), not 6.
- Simultaneous: owner 2 drops req in the same cycle req[5] rises -> GAP cycle with gnt=0, then gnt=8'h20.
- Async reset mid-grant: gnt=8'h08, pull rst_n low mid-cycle -> gnt=0 before the next edge. After release with req=8'h0C -> gnt=8'h04 (ptr=0 restart).
- Timeout (RR_HOLD_TIMEOUT_EN, MAX_HOLD=4): req=8'h03 held -> gnt=8'h01 for 4 cycles, 1 zero cycle, gnt=8'h02 for 4 cycles, 1 zero cycle, gnt=8'h01. Without the macro, gnt=8'h01 persists.
